// File: rtl/sram_sp_be_ctrl.sv
// Single-port SRAM controller with byte-enable writes, valid/ready request and
// response channels, optional read-data register stage and post-reset zero-fill.
module sram_sp_be_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 2**ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic                    addr_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int          IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  logic                  req_fire, rd_fire, wr_fire, rsp_fire, in_range;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Widened compare so NUM_WORDS == 2**ADDR_WIDTH does not overflow the constant.
  assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH+1)'(NUM_WORDS));
  assign req_idx  = req_addr[IDX_W-1:0];
  assign rsp_fire = rsp_valid & rsp_ready;
  assign req_fire = req_valid & req_ready;
  assign rd_fire  = req_fire & ~req_we;
  assign wr_fire  = req_fire & req_we;
  assign rd_word  = in_range ? mem[req_idx] : '0;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= (INIT_ZERO != 0) ? S_INIT : S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state is derived from req_valid/req_we directly so it does not loop
  // back through req_ready.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == LAST) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        if (req_valid && !req_we) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        req_ready = rsp_fire;
        init_done = 1'b1;
        if (rsp_fire && !(req_valid && !req_we)) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (!RSTN) begin
      req_ready = 1'b0;
      init_done = 1'b0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = req_be;
    mem_wdata = req_wdata;
    if (state == S_INIT) begin
      mem_we    = RSTN;
      mem_idx   = init_cnt[IDX_W-1:0];
      mem_be    = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = RSTN & wr_fire & in_range & (|req_be);
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      init_cnt  <= '0;
      addr_err  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
    end else begin
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      if (req_fire && !in_range) addr_err <= 1'b1;
      if (OUT_REG != 0) begin
        // The extra stage is only occupied while rsp_valid is low, so it never
        // collides with a held response.
        s1_valid <= rd_fire;
        if (rd_fire) s1_data <= rd_word;
        if (s1_valid) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= s1_data;
        end else if (rsp_fire) begin
          rsp_valid <= 1'b0;
        end
      end else begin
        if (rd_fire) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_word;
        end else if (rsp_fire) begin
          rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_be_ctrl.sv
// Scoreboard bench for sram_sp_be_ctrl: two configurations (12 words / no output
// register, 16 words / output register) exercised one after the other.
module tb_sram_sp_be_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn, req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done, addr_err;
  logic [4:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [3:0]  req_be    [2];

  sram_sp_be_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_WORDS(12), .OUT_REG(0), .INIT_ZERO(1)) dut0 (
    .CLK(clk), .RSTN(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0][3:0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .init_done(init_done[0]), .addr_err(addr_err[0]));

  sram_sp_be_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_WORDS(16), .OUT_REG(1), .INIT_ZERO(1)) dut1 (
    .CLK(clk), .RSTN(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .init_done(init_done[1]), .addr_err(addr_err[1]));

  int checks = 0, failures = 0, cur = 0, cyc = 0;
  int rr_mode = 0;
  bit gap_chk = 0, have_last = 0;
  int last_cyc = 0;
  logic [31:0] model [32];
  logic        exp_err = 1'b0;
  logic [31:0] expq [$];

  function automatic int nw(input int d);   return (d == 0) ? 12 : 16; endfunction
  function automatic int oreg(input int d); return d; endfunction
  function automatic int aw(input int d);   return 4 + d; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // rsp_ready driver: 0 = held high, 1 = random, 2 = left to the directed tests
  initial forever begin
    @(posedge clk);
    #1;
    if (rr_mode == 0) rsp_ready[cur] = 1'b1;
    else if (rr_mode == 1) rsp_ready[cur] = 1'($urandom_range(0, 1));
  end

  // Monitor: pops one expected word on every response handshake
  initial forever begin
    @(negedge clk);
    if (rstn[cur] && rsp_valid[cur] && rsp_ready[cur]) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp dut%0d: got rdata %h, required no response", cur, rsp_rdata[cur]);
      end else begin
        chk("rsp_rdata", rsp_rdata[cur], expq.pop_front());
      end
      if (gap_chk) begin
        if (have_last) chk("rsp_gap", 32'(cyc - last_cyc), 32'(1 + oreg(cur)));
        have_last = 1;
        last_cyc  = cyc;
      end
    end
  end

  task automatic model_apply(input bit we, input int addr, input logic [31:0] wd, input logic [3:0] be);
    bit in_r;
    in_r = (addr < nw(cur));
    if (!in_r) exp_err = 1'b1;
    if (we) begin
      if (in_r)
        for (int b = 0; b < 4; b++)
          if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
    end else begin
      expq.push_back(in_r ? model[addr] : 32'h0);
    end
  endtask

  task automatic do_req(input bit we, input int addr, input logic [31:0] wd, input logic [3:0] be);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    req_valid[cur] = 1'b1;
    req_we[cur]    = we;
    req_addr[cur]  = addr[4:0];
    req_wdata[cur] = wd;
    req_be[cur]    = be;
    while (!ok && n < 64) begin
      @(negedge clk);
      if (req_ready[cur]) begin
        ok = 1;
        model_apply(we, addr, wd, be);
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout dut%0d: req_ready stayed 0, required acceptance within 64 cycles", cur);
    end
    req_valid[cur] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout dut%0d: %0d responses outstanding, required 0", cur, expq.size());
      expq.delete();
    end
  endtask

  task automatic do_reset(input bit midpulse);
    int n;
    expq.delete();
    @(posedge clk);
    #1 rstn[cur] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("init_done_in_reset", 32'(init_done[cur]), 32'h0);
    chk("req_ready_in_reset", 32'(req_ready[cur]), 32'h0);
    chk("rsp_valid_in_reset", 32'(rsp_valid[cur]), 32'h0);
    @(posedge clk);
    #1 rstn[cur] = 1'b1;
    if (midpulse) begin
      repeat (nw(cur) / 2) @(posedge clk);
      #1 rstn[cur] = 1'b0;
      @(negedge clk);
      chk("init_done_pulse", 32'(init_done[cur]), 32'h0);
      @(posedge clk);
      #1 rstn[cur] = 1'b1;
    end
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      chk("rsp_valid_init", 32'(rsp_valid[cur]), 32'h0);
      if (init_done[cur]) break;
    end
    chk("init_latency", 32'(n), 32'(nw(cur)));
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_err = 1'b0;
    chk("addr_err_after_reset", 32'(addr_err[cur]), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_w;
    rstn      = '0;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
    end

    for (int d = 0; d < 2; d++) begin
      cur     = d;
      rr_mode = 0;
      do_reset(1'b0);

      // zero-fill readback
      for (int a = 0; a < nw(d); a++) do_req(1'b0, a, 32'h0, 4'h0);
      drain();

      // byte-enable merge, then an all-zero enable write that must not alter the word
      do_req(1'b1, 5, 32'hAABBCCDD, 4'b1111);
      do_req(1'b1, 5, 32'h11223344, 4'b0101);
      do_req(1'b0, 5, 32'h0, 4'h0);
      do_req(1'b1, 5, 32'hFFFFFFFF, 4'b0000);
      do_req(1'b0, 5, 32'h0, 4'h0);
      drain();

      // back-to-back read throughput
      for (int a = 0; a < 8; a++) if (a != 5) do_req(1'b1, a, $urandom, 4'hF);
      gap_chk   = 1;
      have_last = 0;
      for (int a = 0; a < 8; a++) do_req(1'b0, a, 32'h0, 4'h0);
      drain();
      gap_chk = 0;

      // stalled response is held and blocks further requests
      rr_mode = 2;
      rsp_ready[d] = 1'b0;
      exp_w = model[5];
      do_req(1'b0, 5, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("req_ready_stall", 32'(req_ready[d]), 32'h0);
        chk("rsp_valid_stall", 32'(rsp_valid[d]), (i >= oreg(d)) ? 32'h1 : 32'h0);
        if (i >= oreg(d)) chk("rsp_rdata_stall", rsp_rdata[d], exp_w);
      end
      @(posedge clk);
      #1 rsp_ready[d] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rsp_valid_after_fire", 32'(rsp_valid[d]), 32'h0);
      chk("req_ready_idle", 32'(req_ready[d]), 32'h1);
      @(posedge clk);
      #1 rr_mode = 0;

      // out-of-range write and read
      do_req(1'b1, nw(d) + 1, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      chk("addr_err_set", 32'(addr_err[d]), 32'h1);
      @(posedge clk);
      #1;
      do_req(1'b0, nw(d) + 1, 32'h0, 4'h0);
      for (int a = 0; a < nw(d); a++) do_req(1'b0, a, 32'h0, 4'h0);
      drain();
      @(negedge clk);
      chk("addr_err_sticky", 32'(addr_err[d]), 32'h1);
      @(posedge clk);
      #1;

      // randomized traffic with random response back-pressure
      rr_mode = 1;
      for (int k = 0; k < 250; k++) begin
        do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << aw(d)) - 1)),
               $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
      rr_mode = 0;
      for (int a = 0; a < nw(d); a++) do_req(1'b0, a, 32'h0, 4'h0);
      drain();
      @(negedge clk);
      chk("addr_err_random", 32'(addr_err[d]), 32'(exp_err));
      @(posedge clk);
      #1;

      // reset while a response is pending, with a second pulse mid zero-fill
      rr_mode = 2;
      rsp_ready[d] = 1'b0;
      do_req(1'b1, 3, 32'h5A5A5A5A, 4'hF);
      do_req(1'b0, 3, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      do_reset(1'b1);
      rr_mode = 0;
      do_req(1'b0, 3, 32'h0, 4'h0);
      do_req(1'b0, nw(d) - 1, 32'h0, 4'h0);
      drain();

      rstn[d]      = 1'b0;
      rsp_ready[d] = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_sp_be_ctrl.md
SRAM_SP_BE_CTRL -- requirements
Module: sram_sp_be_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, meaning word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width; it shall be a multiple of 8.
REQ-003 The block SHALL have parameter NUM_WORDS, default 2**ADDR_WIDTH, meaning implemented depth; it shall be at most 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter OUT_REG, default 0, meaning the number of extra read-data register stages (0 or 1).
REQ-005 The block SHALL have parameter INIT_ZERO, default 1, meaning zero-fill of the array after reset (0 or 1).
REQ-006 CLK  input  1  single clock; all logic on the rising edge.
REQ-007 RSTN  input  1  reset, synchronous and active-low.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted when req_valid and req_ready are both high ("req fire").
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 req_be  input  DATA_WIDTH/8  active-high byte enables; bit i covers wdata[8i+7:8i].
REQ-014 rsp_valid  output  1  read data valid.
REQ-015 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high ("rsp fire").
REQ-016 rsp_rdata  output  DATA_WIDTH  read data.
REQ-017 init_done  output  1  array ready for requests.
REQ-018 addr_err  output  1  sticky out-of-range flag.

Function
REQ-019 The FSM SHALL have three states: INIT, IDLE and RD_WAIT.
REQ-020 INIT SHALL write zero to words 0..NUM_WORDS-1, one word per cycle, in ascending order, and then move to IDLE.
REQ-021 If INIT_ZERO=0, the FSM SHALL go from reset directly to IDLE; the array contents are then undefined.
REQ-022 init_done SHALL be 1 exactly when the state is not INIT.
REQ-023 req_ready SHALL be 0 in INIT, 1 in IDLE, and equal to rsp fire in RD_WAIT.
REQ-024 A write fire SHALL update only the enabled bytes, and the new data SHALL be visible to a read accepted in the next cycle.
REQ-025 A write with req_be all zero SHALL leave the array unchanged.
REQ-026 A write SHALL generate no response and SHALL NOT change the state.
REQ-027 A read fire SHALL move the state to RD_WAIT.
REQ-028 For a read fired in cycle t, rsp_valid SHALL first be high in cycle t+1+OUT_REG, and rsp_rdata SHALL hold the full word.
REQ-029 rsp_valid and rsp_rdata SHALL be held stable until rsp fire.
REQ-030 On rsp fire with no new read fire in the same cycle, rsp_valid SHALL fall in the next cycle and the state SHALL return to IDLE.
REQ-031 A read fire in the same cycle as an rsp fire SHALL keep the state in RD_WAIT; with OUT_REG=0 this gives one read per cycle, with OUT_REG=1 one read every two cycles.
REQ-032 In RD_WAIT, a write fire SHALL be possible only in a cycle with rsp fire, and SHALL NOT alter the pending rsp_rdata.
REQ-033 A request with req_addr >= NUM_WORDS SHALL be accepted; a write is dropped, and a read returns all zeros with normal timing.
REQ-034 Any out-of-range fire SHALL set addr_err to 1 in the next cycle; addr_err clears only on reset.
REQ-035 No other read or write latency SHALL exist; there is no byte-enable effect on reads.

Reset
REQ-036 When RSTN=0 at a rising edge, the block SHALL set: state INIT (IDLE if INIT_ZERO=0), rsp_valid 0, rsp_rdata 0, addr_err 0, init counter 0, output pipeline cleared.
REQ-037 While in reset, req_ready and init_done SHALL be 0.
REQ-038 A reset during INIT SHALL restart the zero-fill from word 0.
REQ-039 A reset during RD_WAIT SHALL discard the pending response without asserting rsp_valid.

Verification
REQ-040 Reset with INIT_ZERO=1, NUM_WORDS=16: init_done SHALL rise exactly 16 cycles after RSTN goes high, and reading words 0..15 SHALL return 0.
REQ-041 Write 0xAABBCCDD to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101, then read addr 5: the response SHALL be 0xAA22CC44.
REQ-042 Back-to-back reads of addr 0..7 with rsp_ready held at 1 and OUT_REG=0: there SHALL be one response per cycle, in order, with no gaps; with OUT_REG=1 there SHALL be a response every second cycle.
REQ-043 A read with rsp_ready held at 0 for 5 cycles: rsp_valid and rsp_rdata SHALL stay stable and req_ready SHALL stay 0; after rsp_ready rises, the FSM SHALL return to IDLE in the next cycle.
REQ-044 NUM_WORDS=12 with a write to addr 13 followed by a read of addr 13: the read SHALL return 0x00000000, addr_err SHALL be 1 and stay 1, and words 0..11 SHALL be unchanged.
REQ-045 RSTN pulsed low for one cycle midway through INIT: the fill SHALL restart, and init_done SHALL rise NUM_WORDS cycles after RSTN returns high.
